clk_div: RTL and testbench

//   Programmable SPI serial-clock generator for the SPI master datapath.

---
 rtl/clk_div.sv | 47 ++++
 tb/tb_clk_div.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div.sv
// Programmable SPI serial-clock generator: spi_clk = m_clk / (2*DIV), registered,
// parked at CPOL while in reset or disabled.
module clk_div #(
  parameter int   DIV  = 4,
  parameter logic CPOL = 1'b0,
  localparam int  CW   = $clog2(DIV) + 1
) (
  output logic spi_clk,
  input  logic m_clk,
  input  logic spi_clk_en,
  input  logic nrst
);

  if (DIV < 1) begin : g_div_check
    $error("clk_div: DIV must be >= 1");
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic          spi_clk_q, spi_clk_d;

  always_comb begin
    cnt_d     = '0;
    spi_clk_d = CPOL;
    if (spi_clk_en) begin
      if (cnt_q == CW'(DIV - 1)) begin
        cnt_d     = '0;
        spi_clk_d = ~spi_clk_q;
      end else begin
        cnt_d     = cnt_q + CW'(1);
        spi_clk_d = spi_clk_q;
      end
    end
  end

  always_ff @(posedge m_clk) begin
    if (nrst) begin
      cnt_q     <= '0;
      spi_clk_q <= CPOL;
    end else begin
      cnt_q     <= cnt_d;
      spi_clk_q <= spi_clk_d;
    end
  end

  assign spi_clk = spi_clk_q;

endmodule

// File: tb/tb_clk_div.sv
// Bench for clk_div: four instances (DIV/CPOL = 4/0, 1/0, 3/0, 4/1) share stimulus;
// expected levels are queued at each rising edge and compared on the falling edge.
module tb_clk_div;

  logic       m_clk = 1'b0;
  logic       nrst  = 1'b0;
  logic       en    = 1'b0;
  logic [3:0] spi;

  localparam int DV [4] = '{4, 1, 3, 4};
  localparam bit CP [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  logic [3:0] sb[$];
  int         ecnt [4];
  int         n_checks = 0;
  int         n_fail   = 0;

  always #50 m_clk = ~m_clk;

  clk_div #(.DIV(4), .CPOL(1'b0)) u_div4 (
    .spi_clk(spi[0]), .m_clk(m_clk), .spi_clk_en(en), .nrst(nrst));
  clk_div #(.DIV(1), .CPOL(1'b0)) u_div1 (
    .spi_clk(spi[1]), .m_clk(m_clk), .spi_clk_en(en), .nrst(nrst));
  clk_div #(.DIV(3), .CPOL(1'b0)) u_div3 (
    .spi_clk(spi[2]), .m_clk(m_clk), .spi_clk_en(en), .nrst(nrst));
  clk_div #(.DIV(4), .CPOL(1'b1)) u_div4_cpol1 (
    .spi_clk(spi[3]), .m_clk(m_clk), .spi_clk_en(en), .nrst(nrst));

  // Expected level = CPOL xor parity of completed half-periods since the last restart.
  task automatic cycle();
    logic [3:0] e;
    @(posedge m_clk);
    for (int i = 0; i < 4; i++) begin
      if (nrst || !en) ecnt[i] = 0;
      else             ecnt[i]++;
      e[i] = CP[i] ^ (((ecnt[i] / DV[i]) % 2) == 1);
    end
    sb.push_back(e);
    @(negedge m_clk);
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    nrst = 1'b1;
    en   = 1'b1;
    cycle();
    exp = sb.pop_front();
    n_checks++;
    if (spi !== exp) begin
      n_fail++;
      $display("FAIL reset_sb: spi=%b expected %b", spi, exp);
    end
    n_checks++;
    if (spi !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_level: spi=%b expected %b", spi, 4'b1000);
    end
    nrst = 1'b0;
  endtask

  task automatic test_enable();
    logic [3:0] exp;
    int first = 0;
    en = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      cycle();
      exp = sb.pop_front();
      n_checks++;
      if (spi !== exp) begin
        n_fail++;
        $display("FAIL enable_sb cycle %0d: spi=%b expected %b", c, spi, exp);
      end
      if (first == 0 && spi[0] === 1'b1) first = c;
    end
    n_checks++;
    if (first != 4) begin
      n_fail++;
      $display("FAIL enable_first_rise: edge %0d expected 4", first);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp;
    int first = 0;
    n_checks++;
    if (spi[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_pre: spi[0]=%b expected 1", spi[0]);
    end
    nrst = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      cycle();
      exp = sb.pop_front();
      n_checks++;
      if (spi !== exp || spi !== 4'b1000) begin
        n_fail++;
        $display("FAIL reset_mid_hold cycle %0d: spi=%b expected %b", c, spi, 4'b1000);
      end
    end
    nrst = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      cycle();
      exp = sb.pop_front();
      n_checks++;
      if (spi !== exp) begin
        n_fail++;
        $display("FAIL reset_mid_sb cycle %0d: spi=%b expected %b", c, spi, exp);
      end
      if (first == 0 && spi[0] === 1'b1) first = c;
    end
    n_checks++;
    if (first != 4) begin
      n_fail++;
      $display("FAIL reset_mid_first_rise: edge %0d expected 4", first);
    end
  endtask

  task automatic test_disable();
    logic [3:0] exp;
    int first = 0;
    int guard = 0;
    while (spi[0] !== 1'b1 && guard < 16) begin
      cycle();
      exp = sb.pop_front();
      n_checks++;
      if (spi !== exp) begin
        n_fail++;
        $display("FAIL disable_pre_sb: spi=%b expected %b", spi, exp);
      end
      guard++;
    end
    n_checks++;
    if (spi[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL disable_pre_high: spi[0]=%b expected 1", spi[0]);
    end
    en = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      cycle();
      exp = sb.pop_front();
      n_checks++;
      if (spi !== exp || spi !== 4'b1000) begin
        n_fail++;
        $display("FAIL disable_hold cycle %0d: spi=%b expected %b", c, spi, 4'b1000);
      end
    end
    en = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      cycle();
      exp = sb.pop_front();
      n_checks++;
      if (spi !== exp) begin
        n_fail++;
        $display("FAIL reenable_sb cycle %0d: spi=%b expected %b", c, spi, exp);
      end
      if (first == 0 && spi[0] === 1'b1) first = c;
    end
    n_checks++;
    if (first != 4) begin
      n_fail++;
      $display("FAIL reenable_first_rise: edge %0d expected 4", first);
    end
  endtask

  task automatic test_div_variants();
    logic [3:0] exp;
    logic       prev;
    nrst = 1'b1;
    en   = 1'b0;
    cycle();
    exp = sb.pop_front();
    nrst = 1'b0;
    en   = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      prev = spi[1];
      cycle();
      exp = sb.pop_front();
      n_checks++;
      if (spi !== exp) begin
        n_fail++;
        $display("FAIL div_sb cycle %0d: spi=%b expected %b", c, spi, exp);
      end
      n_checks++;
      if (spi[1] !== ~prev) begin
        n_fail++;
        $display("FAIL div1_toggle cycle %0d: spi[1]=%b expected %b", c, spi[1], ~prev);
      end
    end
  endtask

  task automatic test_free_run();
    logic [3:0] exp;
    logic [2:0] last;
    int         len [3];
    bit         seen [3];
    int         toggles = 0;
    nrst = 1'b1;
    en   = 1'b0;
    cycle();
    exp = sb.pop_front();
    nrst = 1'b0;
    en   = 1'b1;
    last = spi[2:0];
    for (int i = 0; i < 3; i++) begin
      len[i]  = 0;
      seen[i] = 1'b0;
    end
    for (int c = 1; c <= 800; c++) begin
      cycle();
      exp = sb.pop_front();
      n_checks++;
      if (spi !== exp) begin
        n_fail++;
        $display("FAIL free_sb cycle %0d: spi=%b expected %b", c, spi, exp);
      end
      for (int i = 0; i < 3; i++) begin
        if (spi[i] !== last[i]) begin
          if (i == 0) toggles++;
          if (seen[i]) begin
            n_checks++;
            if (len[i] != DV[i]) begin
              n_fail++;
              $display("FAIL free_pulse_width inst %0d cycle %0d: width %0d expected %0d",
                       i, c, len[i], DV[i]);
            end
          end
          seen[i] = 1'b1;
          len[i]  = 1;
        end else begin
          len[i]++;
        end
      end
      last = spi[2:0];
    end
    n_checks++;
    if (toggles != 200) begin
      n_fail++;
      $display("FAIL free_toggle_count: %0d toggles expected 200", toggles);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) ecnt[i] = 0;
    @(negedge m_clk);
    test_reset();
    test_enable();
    test_reset_mid();
    test_disable();
    test_div_variants();
    test_free_run();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
